// File: rtl/vga_block_pkg.sv
// Shared constants and enums for the multi-block VGA pixel generator.
// Screen defaults, colours, palette, operating mode and update-FSM states.
package vga_block_pkg;

  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;

  localparam logic [11:0] COLOR_BG  = 12'hFFF;
  localparam logic [11:0] COLOR_SEL = 12'h000;

  // Entry 0 is the rightmost element.
  localparam logic [7:0][11:0] PALETTE = {
    12'h888, 12'hF80, 12'h0FF, 12'hF0F,
    12'hFF0, 12'h00F, 12'h0F0, 12'hF00
  };

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_UPD  = 1'b1
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-FF synchroniser, stability-window debouncer, 1-cycle press pulse.
// Press pulse appears DEB_CYCLES+2 cycles after a clean raw falling edge; no backpressure.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        // A released level turning low is the press.
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_level;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/vga_block_engine.sv
// Multi-block pixel generator: per-frame block update FSM plus registered 1-cycle pixel lookup.
// No backpressure; VGA_BLOCK_AUTO_EN builds the bouncing AUTO mode, otherwise manual only.
module vga_block_engine
  import vga_block_pkg::*;
#(
  parameter int H_DISP     = H_DISP_DEF,
  parameter int V_DISP     = V_DISP_DEF,
  parameter int BLOCK_W    = 20,
  parameter int NUM_BLOCKS = 4,
  parameter int STEP       = 2,
  parameter int DEB_CYCLES = 500000
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  key,
  input  logic [9:0]  pixel_xpos,
  input  logic [9:0]  pixel_ypos,
  output logic [11:0] pixel_data,
  output logic [2:0]  sel_idx,
  output logic        mode
);

  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic signed [10:0] X_MAX  = 11'(H_DISP - BLOCK_W);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  logic [3:0] w_lvl;
  logic [3:0] w_press;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (vga_clk),
      .i_rst_n (sys_rst_n),
      .i_key   (key[k]),
      .o_level (w_lvl[k]),
      .o_press (w_press[k])
    );
  end

  logic w_unused;
  assign w_unused = &{1'b0, w_lvl[3:2], w_press[1:0], w_press[3]};

  logic [2:0] r_sel;
  mode_t      w_mode;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sel <= '0;
    end else if (w_press[2]) begin
      r_sel <= (r_sel == 3'(NUM_BLOCKS - 1)) ? 3'd0 : r_sel + 3'd1;
    end
  end

`ifdef VGA_BLOCK_AUTO_EN
  localparam logic signed [10:0] Y_MAX = 11'(V_DISP - BLOCK_W);
  mode_t r_mode;
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode <= MODE_MANUAL;
    end else if (w_press[3]) begin
      r_mode <= (r_mode == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
    end
  end
  assign w_mode = r_mode;
`else
  assign w_mode = MODE_MANUAL;
`endif

  logic w_frame_tick;
  assign w_frame_tick = (pixel_xpos == 10'(H_DISP - 1)) && (pixel_ypos == 10'(V_DISP - 1));

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_sel_l;
  logic             r_left_l;
  logic             r_right_l;
  logic [9:0]       r_x [NUM_BLOCKS];
  logic [9:0]       r_y [NUM_BLOCKS];
`ifdef VGA_BLOCK_AUTO_EN
  mode_t            r_mode_l;
  logic             r_dx_neg [NUM_BLOCKS];
  logic             r_dy_neg [NUM_BLOCKS];
`endif

  logic signed [10:0] w_cx;
  logic signed [10:0] w_nx_man;

  always_comb begin
    w_cx     = $signed({1'b0, r_x[r_idx]});
    w_nx_man = w_cx;
    if (r_idx == r_sel_l && r_left_l && !r_right_l) begin
      w_nx_man = w_cx - STEP_S;
      if (w_nx_man < 11'sd0) w_nx_man = '0;
    end else if (r_idx == r_sel_l && r_right_l && !r_left_l) begin
      w_nx_man = w_cx + STEP_S;
      if (w_nx_man > X_MAX) w_nx_man = X_MAX;
    end
  end

`ifdef VGA_BLOCK_AUTO_EN
  logic signed [10:0] w_cy;
  logic signed [10:0] w_nx_auto;
  logic signed [10:0] w_ny_auto;
  logic               w_flip_x;
  logic               w_flip_y;

  // Hitting an edge clamps to it and reverses in the same cycle.
  always_comb begin
    w_cy      = $signed({1'b0, r_y[r_idx]});
    w_flip_x  = 1'b0;
    w_flip_y  = 1'b0;
    w_nx_auto = r_dx_neg[r_idx] ? w_cx - STEP_S : w_cx + STEP_S;
    w_ny_auto = r_dy_neg[r_idx] ? w_cy - STEP_S : w_cy + STEP_S;
    if (w_nx_auto > X_MAX) begin
      w_nx_auto = X_MAX;
      w_flip_x  = 1'b1;
    end else if (w_nx_auto < 11'sd0) begin
      w_nx_auto = '0;
      w_flip_x  = 1'b1;
    end
    if (w_ny_auto > Y_MAX) begin
      w_ny_auto = Y_MAX;
      w_flip_y  = 1'b1;
    end else if (w_ny_auto < 11'sd0) begin
      w_ny_auto = '0;
      w_flip_y  = 1'b1;
    end
  end
`endif

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_sel_l   <= '0;
      r_left_l  <= 1'b0;
      r_right_l <= 1'b0;
`ifdef VGA_BLOCK_AUTO_EN
      r_mode_l  <= MODE_MANUAL;
`endif
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_x[i] <= 10'(i * 2 * BLOCK_W);
        r_y[i] <= 10'(i * 2 * BLOCK_W);
`ifdef VGA_BLOCK_AUTO_EN
        r_dx_neg[i] <= 1'b0;
        r_dy_neg[i] <= 1'b0;
`endif
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_frame_tick) begin
            r_sel_l   <= r_sel[IDX_W-1:0];
            r_left_l  <= ~w_lvl[0];
            r_right_l <= ~w_lvl[1];
`ifdef VGA_BLOCK_AUTO_EN
            r_mode_l  <= r_mode;
`endif
            r_idx     <= '0;
            r_state   <= ST_UPD;
          end
        end
        ST_UPD: begin
`ifdef VGA_BLOCK_AUTO_EN
          if (r_mode_l == MODE_AUTO) begin
            r_x[r_idx]      <= w_nx_auto[9:0];
            r_y[r_idx]      <= w_ny_auto[9:0];
            r_dx_neg[r_idx] <= r_dx_neg[r_idx] ^ w_flip_x;
            r_dy_neg[r_idx] <= r_dy_neg[r_idx] ^ w_flip_y;
          end else begin
            r_x[r_idx] <= w_nx_man[9:0];
          end
`else
          r_x[r_idx] <= w_nx_man[9:0];
`endif
          if (r_idx == IDX_W'(NUM_BLOCKS - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [11:0] w_pix;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [11:0] r_pix;

  // Scan high to low so the lowest index is written last and wins.
  always_comb begin
    w_pix = COLOR_BG;
    w_dx  = '0;
    w_dy  = '0;
    if ({1'b0, pixel_xpos} < 11'(H_DISP) && {1'b0, pixel_ypos} < 11'(V_DISP)) begin
      for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
        w_dx = {1'b0, pixel_xpos} - {1'b0, r_x[i]};
        w_dy = {1'b0, pixel_ypos} - {1'b0, r_y[i]};
        if (w_dx < 11'(BLOCK_W) && w_dy < 11'(BLOCK_W)) begin
          if (w_mode == MODE_MANUAL && r_sel == 3'(i) &&
              (w_dx < 11'd2 || w_dx >= 11'(BLOCK_W - 2) ||
               w_dy < 11'd2 || w_dy >= 11'(BLOCK_W - 2))) begin
            w_pix = COLOR_SEL;
          end else begin
            w_pix = PALETTE[i];
          end
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix <= COLOR_BG;
    end else begin
      r_pix <= w_pix;
    end
  end

  assign pixel_data = r_pix;
  assign sel_idx    = r_sel;
  assign mode       = (w_mode == MODE_AUTO);

endmodule

// File: doc/vga_block_engine.md
# vga_block_engine

Multi-block pixel generator replacing the single-block display stage between the VGA timing driver and the board keys. Holds NUM_BLOCKS coloured squares, updates their positions once per frame, and returns the 12-bit RGB for the pixel coordinate requested by the driver. In manual mode the keys move a selected block. In auto mode every block bounces off the screen edges.

## Interface
- H_DISP, 640, visible pixels per line
- V_DISP, 480, visible lines per frame
- BLOCK_W, 20, block side length in pixels
- NUM_BLOCKS, 4, block count, 1..8; must satisfy NUM_BLOCKS*2*BLOCK_W <= V_DISP
- STEP, 2, pixels moved per frame per axis
- DEB_CYCLES, 500000, debounce stability window in vga_clk cycles
- vga_clk  in  1  pixel clock, 25 MHz
- sys_rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- key  in  4  raw buttons, active-low: [0] left, [1] right, [2] select-next, [3] mode toggle
- pixel_xpos  in  10  requested pixel column
- pixel_ypos  in  10  requested pixel line
- pixel_data  out  12  RGB444 for the requested pixel
- sel_idx  out  3  index of the selected block
- mode  out  1  0 = MANUAL, 1 = AUTO

## Operation
- Keys:
  - Each key passes through a 2-FF synchroniser, then a debouncer.
  - The debounced level changes only after the input is stable for DEB_CYCLES cycles.
  - A press event is a 1-cycle pulse on a debounced high-to-low transition.
- Select-next press: sel_idx increments and wraps from NUM_BLOCKS-1 to 0.
- Mode press: mode toggles.
- Frame tick: 1-cycle pulse when pixel_xpos==H_DISP-1 and pixel_ypos==V_DISP-1.
- Update FSM:
  - IDLE: on frame tick, latch sel_idx, mode and the debounced left/right levels, clear idx, go to UPD.
  - UPD: update block idx (one block per cycle); at idx==NUM_BLOCKS-1 return to IDLE.
- MANUAL update (selected block only):
  - Left only: x -= STEP, clamped at 0.
  - Right only: x += STEP, clamped at H_DISP-BLOCK_W.
  - Both or neither held: no change.
- AUTO update (every block):
  - Per axis, position moves STEP in its direction.
  - If the next position would pass 0 or the limit (H_DISP-BLOCK_W, V_DISP-BLOCK_W), clamp it to that limit and invert the direction bit in the same cycle.
- Position arithmetic is 11-bit signed before clamping; stored positions are 10-bit.
- Render:
  - A pixel is inside block i if x_i <= xpos < x_i+BLOCK_W and y_i <= ypos < y_i+BLOCK_W.
  - The lowest index wins on overlap.
  - Block colour comes from PALETTE[i]; background is 12'hFFF.
  - In MANUAL mode the outer 2 px ring of the selected block is 12'h000.
  - Coordinates at or beyond H_DISP/V_DISP give background.
- Reset values:
  - x_i = i*2*BLOCK_W, y_i = i*2*BLOCK_W; all direction bits = +x, +y.
  - sel_idx=0, mode=0, pixel_data=12'hFFF, FSM=IDLE, debounced levels=1 (released).
- A mode toggle keeps current positions and direction bits.
- A select press during UPD changes sel_idx at once; the running update still uses the latched value.
- Asserting reset mid-UPD abandons the update and all state returns to its reset values.

## Timing
- pixel_data is registered: valid 1 cycle after pixel_xpos/ypos.
- The update completes NUM_BLOCKS+1 cycles after the frame tick, inside vertical blanking. Visible pixels never see a partially updated set.
- A key press takes effect at most DEB_CYCLES+3 cycles after the raw edge. Movement applies at the next frame tick.
- sel_idx and mode change 1 cycle after the press pulse.

## Configuration
- VGA_BLOCK_AUTO_EN defined: AUTO mode, direction registers and the y-movement logic are built.
- VGA_BLOCK_AUTO_EN undefined: key[3] is ignored, mode is tied to 0, and no direction registers exist. Behaviour is otherwise identical.

## Structure
- Package vga_block_pkg holds:
  - Default H_DISP/V_DISP.
  - COLOR_BG (12'hFFF) and COLOR_SEL (12'h000).
  - The 8-entry PALETTE constant.
  - The mode enum (MODE_MANUAL, MODE_AUTO).
  - The FSM state enum (ST_IDLE, ST_UPD).
- One sub-module, key_debounce (synchroniser, debounce counter, press pulse), instantiated 4 times.

## Test plan
- Reset, with DEB_CYCLES=4 in the bench: sample pixel (0,0) -> PALETTE[0] with a black ring pixel; sample (639,479) -> 12'hFFF.
- Hold key[1] low for 10 frames in MANUAL with STEP=2 -> x_0 = 20 and every other block unchanged.
- Hold key[0] for 5 frames from x_0=0 -> x_0 stays 0. Hold key[0] and key[1] together -> no movement.
- 4 select presses with NUM_BLOCKS=4 -> sel_idx goes 1,2,3,0.
- Mode press, then run frames with block 0 at x=620 moving +x -> x clamps to 620, direction flips, next frame x=618.
- Assert reset mid-UPD -> all positions, sel_idx and mode return to their reset values on the next cycle.
